// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode constants, datapath select codes and the control-word layout.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full set of datapath control strobes produced each cycle.
    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Bundle between the controller core and its datapath: status in,
// control word and retire/illegal strobes out.
interface mc_control_if;
    import mips_ctrl_pkg::*;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [3:0] state;
    ctrl_t      ctrl;
    logic       instr_done;
    logic       illegal;

    // The controller side consumes status and drives control.
    modport master (
        input  opcode, zero, mem_ready, state,
        output ctrl, instr_done, illegal
    );

    // The datapath side supplies status and consumes control.
    modport slave (
        output opcode, zero, mem_ready, state,
        input  ctrl, instr_done, illegal
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the current state (plus mem_ready/zero for the
// handshake-qualified strobes) onto the control word.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    mc_control_if.master bus
);

    ctrl_t ctrl_c;
    logic  done_c;
    logic  illegal_c;

    // Per-state control word; opcode only matters in DECODE for the illegal flag.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ctrl_c    = '0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        case (state_e'(bus.state))
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.ir_write  = bus.mem_ready;
                ctrl_c.pc_en     = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = SRCB_SHIMM;
                illegal_c        = !is_supported(bus.opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_c.iord     = 1'b1;
                ctrl_c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                done_c            = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.iord      = 1'b1;
                ctrl_c.mem_write = 1'b1;
                done_c           = bus.mem_ready;
            end
            S_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                done_c           = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALUOP_SUB;
                ctrl_c.pc_src    = PCSRC_ALUOUT;
                ctrl_c.pc_en     = bus.zero;
                done_c           = 1'b1;
            end
            S_JUMP: begin
                ctrl_c.pc_src = PCSRC_JUMP;
                ctrl_c.pc_en  = 1'b1;
                done_c        = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_c.reg_write = 1'b1;
                done_c           = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ctrl       = ctrl_c;
    assign bus.instr_done = done_c;
    assign bus.illegal    = illegal_c;

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control unit: state register and next-state logic; the
// control word comes from mc_ctrl_decode.
module mc_control
    import mips_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_c_pcEn,
    output logic [1:0] o_c_pcSrc,
    output logic       o_c_iorD,
    output logic       o_c_memRead,
    output logic       o_c_memWrite,
    output logic       o_c_irWrite,
    output logic       o_c_regDst,
    output logic       o_c_memToReg,
    output logic       o_c_regWrite,
    output logic       o_c_aluSrcA,
    output logic [1:0] o_c_aluSrcB,
    output logic [1:0] o_c_aluOp,
    output logic       o_instr_done,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    state_e state_q;
    state_e state_d;

    mc_control_if u_bus ();

    assign u_bus.opcode    = i_opcode;
    assign u_bus.zero      = i_zero;
    assign u_bus.mem_ready = i_mem_ready;
    assign u_bus.state     = state_q;

    mc_ctrl_decode u_decode (
        .bus (u_bus)
    );

    // Instruction sequencing; memory-facing states hold until mem_ready.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (i_opcode)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD:  state_d = i_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = i_mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset that overrides any pending handshake.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignment to avoid ordering races.
        if (i_rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_c_pcEn     = u_bus.ctrl.pc_en;
    assign o_c_pcSrc    = u_bus.ctrl.pc_src;
    assign o_c_iorD     = u_bus.ctrl.iord;
    assign o_c_memRead  = u_bus.ctrl.mem_read;
    assign o_c_memWrite = u_bus.ctrl.mem_write;
    assign o_c_irWrite  = u_bus.ctrl.ir_write;
    assign o_c_regDst   = u_bus.ctrl.reg_dst;
    assign o_c_memToReg = u_bus.ctrl.mem_to_reg;
    assign o_c_regWrite = u_bus.ctrl.reg_write;
    assign o_c_aluSrcA  = u_bus.ctrl.alu_src_a;
    assign o_c_aluSrcB  = u_bus.ctrl.alu_src_b;
    assign o_c_aluOp    = u_bus.ctrl.alu_op;

    // Reset masks the status outputs so an abandoned instruction never retires.
    assign o_instr_done = u_bus.instr_done & ~i_rst;
    assign o_illegal    = u_bus.illegal & ~i_rst;
    assign o_state      = i_rst ? 4'd0 : u_bus.state;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed vector table, hand-written
// stall/reset sequences, then random traffic against an instruction-walk model.
module tb_mc_control;

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;

    mc_control_if bus ();

    mc_control dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_opcode     (bus.opcode),
        .i_zero       (bus.zero),
        .i_mem_ready  (bus.mem_ready),
        .o_c_pcEn     (bus.ctrl.pc_en),
        .o_c_pcSrc    (bus.ctrl.pc_src),
        .o_c_iorD     (bus.ctrl.iord),
        .o_c_memRead  (bus.ctrl.mem_read),
        .o_c_memWrite (bus.ctrl.mem_write),
        .o_c_irWrite  (bus.ctrl.ir_write),
        .o_c_regDst   (bus.ctrl.reg_dst),
        .o_c_memToReg (bus.ctrl.mem_to_reg),
        .o_c_regWrite (bus.ctrl.reg_write),
        .o_c_aluSrcA  (bus.ctrl.alu_src_a),
        .o_c_aluSrcB  (bus.ctrl.alu_src_b),
        .o_c_aluOp    (bus.ctrl.alu_op),
        .o_instr_done (bus.instr_done),
        .o_illegal    (bus.illegal),
        .o_state      (bus.state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic       z;
        int         st;
        logic       done;
        logic       ill;
    } vec_t;

    // Expected control word per state, straight from the output table.
    // Order: pcEn pcSrc iorD memRead memWrite irWrite regDst memToReg regWrite aluSrcA aluSrcB aluOp
    function automatic logic [14:0] ctrl_exp(input int st, input logic rdy, input logic z);
        logic pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] pc_src, srcb, aluop;
        {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, srca} = '0;
        pc_src = 2'b00; srcb = 2'b00; aluop = 2'b00;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pc_en = rdy; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mwr = 1; end
            6:  begin srca = 1; aluop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin srca = 1; aluop = 2'b01; pc_src = 2'b01; pc_en = z; end
            9:  begin pc_src = 2'b10; pc_en = 1; end
            10: begin srca = 1; srcb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pc_en, pc_src, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aluop};
    endfunction

    // Number of states an instruction walks through, FETCH included.
    function automatic int path_len(input logic [5:0] op);
        case (op)
            6'b000000: return 4;
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // The idx-th state visited by an instruction with this opcode.
    function automatic int path_state(input logic [5:0] op, input int idx);
        if (idx == 0) return 0;
        if (idx == 1) return 1;
        case (op)
            6'b000000: return (idx == 2) ? 6 : 7;
            6'b100011: return (idx == 2) ? 2 : ((idx == 3) ? 3 : 4);
            6'b101011: return (idx == 2) ? 2 : 5;
            6'b000100: return 8;
            6'b001000: return (idx == 2) ? 10 : 11;
            6'b000010: return 9;
            default:   return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle of inputs, compare all outputs mid-cycle, then clock.
    task automatic step(input logic r, input logic [5:0] op, input logic rdy, input logic z,
                        input int es, input logic ed, input logic ei,
                        input logic [14:0] ec, input string tag);
        logic [14:0] act;
        rst = r; bus.opcode = op; bus.mem_ready = rdy; bus.zero = z;
        @(negedge clk);
        act = {bus.ctrl.pc_en, bus.ctrl.pc_src, bus.ctrl.iord, bus.ctrl.mem_read,
               bus.ctrl.mem_write, bus.ctrl.ir_write, bus.ctrl.reg_dst, bus.ctrl.mem_to_reg,
               bus.ctrl.reg_write, bus.ctrl.alu_src_a, bus.ctrl.alu_src_b, bus.ctrl.alu_op};
        check({tag, " state"}, 32'(bus.state), 32'(es));
        check({tag, " ctrl"}, 32'(act), 32'(ec));
        check({tag, " done"}, 32'(bus.instr_done), 32'(ed));
        check({tag, " illegal"}, 32'(bus.illegal), 32'(ei));
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input logic r, input logic [5:0] op, input logic rdy, input logic z,
                       input int es, input logic ed, input logic ei, input string tag);
        step(r, op, rdy, z, es, ed, ei, ctrl_exp(es, rdy, z), tag);
    endtask

    vec_t tbl[21];

    initial begin
        int idx;
        logic [5:0] op;
        logic rdy, z, r, last, adv, sup;
        int st;

        rst = 1'b1; bus.opcode = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
        @(posedge clk);
        #1;

        // Reset, R-type, beq taken/not taken, j, addi, illegal opcode.
        tbl[0]  = '{1'b1, 6'h00, 1'b1, 1'b0, 0,  1'b0, 1'b0};
        tbl[1]  = '{1'b0, 6'h00, 1'b1, 1'b0, 0,  1'b0, 1'b0};
        tbl[2]  = '{1'b0, 6'h00, 1'b1, 1'b0, 1,  1'b0, 1'b0};
        tbl[3]  = '{1'b0, 6'h00, 1'b1, 1'b0, 6,  1'b0, 1'b0};
        tbl[4]  = '{1'b0, 6'h00, 1'b1, 1'b0, 7,  1'b1, 1'b0};
        tbl[5]  = '{1'b0, 6'h04, 1'b1, 1'b1, 0,  1'b0, 1'b0};
        tbl[6]  = '{1'b0, 6'h04, 1'b1, 1'b1, 1,  1'b0, 1'b0};
        tbl[7]  = '{1'b0, 6'h04, 1'b1, 1'b1, 8,  1'b1, 1'b0};
        tbl[8]  = '{1'b0, 6'h04, 1'b1, 1'b0, 0,  1'b0, 1'b0};
        tbl[9]  = '{1'b0, 6'h04, 1'b1, 1'b0, 1,  1'b0, 1'b0};
        tbl[10] = '{1'b0, 6'h04, 1'b1, 1'b0, 8,  1'b1, 1'b0};
        tbl[11] = '{1'b0, 6'h02, 1'b1, 1'b0, 0,  1'b0, 1'b0};
        tbl[12] = '{1'b0, 6'h02, 1'b1, 1'b0, 1,  1'b0, 1'b0};
        tbl[13] = '{1'b0, 6'h02, 1'b1, 1'b0, 9,  1'b1, 1'b0};
        tbl[14] = '{1'b0, 6'h08, 1'b1, 1'b0, 0,  1'b0, 1'b0};
        tbl[15] = '{1'b0, 6'h08, 1'b1, 1'b0, 1,  1'b0, 1'b0};
        tbl[16] = '{1'b0, 6'h08, 1'b1, 1'b0, 10, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 6'h08, 1'b1, 1'b0, 11, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 6'h3F, 1'b1, 1'b0, 0,  1'b0, 1'b0};
        tbl[19] = '{1'b0, 6'h3F, 1'b1, 1'b0, 1,  1'b0, 1'b1};
        tbl[20] = '{1'b0, 6'h3F, 1'b1, 1'b0, 0,  1'b0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            vec(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].z, tbl[i].st,
                tbl[i].done, tbl[i].ill, $sformatf("tbl%0d", i));
        end

        // lw with three stall cycles in MEMRD.
        vec(0, 6'h23, 1, 0, 1, 0, 0, "lw decode");
        vec(0, 6'h23, 1, 0, 2, 0, 0, "lw memadr");
        for (int i = 0; i < 3; i++) vec(0, 6'h23, 0, 0, 3, 0, 0, $sformatf("lw stall%0d", i));
        vec(0, 6'h23, 1, 0, 3, 0, 0, "lw memrd ready");
        vec(0, 6'h23, 1, 0, 4, 1, 0, "lw memwb");

        // sw abandoned by reset while MEMWR waits on memory.
        vec(0, 6'h2B, 1, 0, 0, 0, 0, "sw fetch");
        vec(0, 6'h2B, 1, 0, 1, 0, 0, "sw decode");
        vec(0, 6'h2B, 1, 0, 2, 0, 0, "sw memadr");
        vec(0, 6'h2B, 0, 0, 5, 0, 0, "sw memwr wait");
        step(1, 6'h2B, 0, 0, 0, 0, 0, ctrl_exp(5, 0, 0), "sw reset");
        vec(0, 6'h2B, 0, 0, 0, 0, 0, "sw after reset");

        // FETCH stalled two cycles, then an R-type completes.
        vec(0, 6'h00, 0, 0, 0, 0, 0, "fetch stall1");
        vec(0, 6'h00, 1, 0, 0, 0, 0, "fetch ready");
        vec(0, 6'h00, 1, 0, 1, 0, 0, "fetch decode");
        vec(0, 6'h00, 1, 0, 6, 0, 0, "rtype exec");
        vec(0, 6'h00, 1, 0, 7, 1, 0, "rtype aluwb");

        // Random traffic against the instruction-walk model.
        step(1, 6'h00, 1, 0, 0, 0, 0, ctrl_exp(0, 1, 0), "rand reset");
        idx = 0;
        op = 6'h00;
        for (int i = 0; i < 1500; i++) begin
            if (idx == 0) begin
                case ($urandom_range(0, 7))
                    0: op = 6'b000000;
                    1: op = 6'b100011;
                    2: op = 6'b101011;
                    3: op = 6'b000100;
                    4: op = 6'b001000;
                    5: op = 6'b000010;
                    default: op = 6'($urandom_range(0, 63));
                endcase
            end
            rdy  = ($urandom_range(0, 3) != 0);
            z    = 1'($urandom_range(0, 1));
            r    = ($urandom_range(0, 63) == 0);
            st   = path_state(op, idx);
            last = (idx == path_len(op) - 1);
            adv  = !(st inside {0, 3, 5}) || rdy;
            sup  = (path_len(op) != 2);
            if (r) begin
                step(1, op, rdy, z, 0, 0, 0, ctrl_exp(st, rdy, z), $sformatf("rand%0d rst", i));
                idx = 0;
            end else begin
                step(0, op, rdy, z, st, last && adv && sup, (st == 1) && !sup,
                     ctrl_exp(st, rdy, z), $sformatf("rand%0d", i));
                if (adv) idx = last ? 0 : idx + 1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL use one clock, i_clk; reset is synchronous and active-high, port i_rst; there are no parameters.
REQ-002 Port list, each SHALL be exactly:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_opcode  in  6  instruction register opcode field [31:26]
- i_zero  in  1  ALU zero flag
- i_mem_ready  in  1  memory completes the current access this cycle
- o_c_pcEn  out  1  PC register write enable
- o_c_pcSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- o_c_iorD  out  1  0 PC address, 1 ALUOut address
- o_c_memRead  out  1  memory read request
- o_c_memWrite  out  1  memory write request
- o_c_irWrite  out  1  instruction register load
- o_c_regDst  out  1  write address select, 0 Rt, 1 Rd (drives decode i_c_regDst)
- o_c_memToReg  out  1  write data select, 0 ALUOut, 1 memory data
- o_c_regWrite  out  1  register file write enable (drives decode i_c_regWrite)
- o_c_aluSrcA  out  1  0 PC, 1 register operand 1
- o_c_aluSrcB  out  2  00 operand 2, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate
- o_c_aluOp  out  2  00 add, 01 subtract, 10 use funct
- o_instr_done  out  1  one-cycle retire pulse
- o_illegal  out  1  one-cycle unsupported-opcode pulse
- o_state  out  4  current state encoding

Function
REQ-003 The block SHALL be a multicycle Moore FSM with 4-bit state: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-004 Transitions SHALL be:
- FETCH->DECODE when i_mem_ready=1; otherwise stay in FETCH.
- DECODE by opcode: 000000->EXEC, 100011 or 101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other->FETCH.
- MEMADR: lw->MEMRD, sw->MEMWR.
- MEMRD->MEMWB when i_mem_ready=1, else stay.
- MEMWR->FETCH when i_mem_ready=1, else stay.
- EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-005 In MEMADR the opcode SHALL be sampled from i_opcode, which is held stable by the instruction register.
REQ-006 Encodings 12-15 SHALL go to FETCH on the next edge, with all control outputs 0.
REQ-007 Per-state outputs SHALL be as follows; every output not listed is 0:
- FETCH: memRead=1, aluSrcB=01, irWrite=pcEn=i_mem_ready.
- DECODE: aluSrcB=11.
- MEMADR: aluSrcA=1, aluSrcB=10.
- MEMRD: iorD=1, memRead=1.
- MEMWB: memToReg=1, regWrite=1.
- MEMWR: iorD=1, memWrite=1.
- EXEC: aluSrcA=1, aluOp=10.
- ALUWB: regDst=1, regWrite=1.
- BRANCH: aluSrcA=1, aluOp=01, pcSrc=01, pcEn=i_zero.
- ADDIEX: aluSrcA=1, aluSrcB=10.
- ADDIWB: regWrite=1.
- JUMP: pcSrc=10, pcEn=1.
REQ-008 While waiting on memory, memRead/memWrite and iorD SHALL stay asserted every stall cycle; irWrite and pcEn SHALL not pulse until the ready cycle.
REQ-009 o_instr_done SHALL pulse in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and in MEMWR only when i_mem_ready=1.
REQ-010 o_illegal SHALL pulse in DECODE for an unsupported opcode; no register or memory write SHALL occur for that instruction.
REQ-011 With i_mem_ready held at 1, latencies SHALL be: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles from FETCH entry to the next FETCH.
REQ-012 Outputs SHALL be combinational from state plus i_mem_ready/i_zero only, with no opcode-dependent glitching outside DECODE/MEMADR.

Reset
REQ-013 When i_rst=1 at a rising edge, state SHALL become FETCH, regardless of state or pending handshake; reset wins over i_mem_ready.
REQ-014 During reset and on the first cycle after it, o_state=0, o_instr_done=0 and o_illegal=0.
REQ-015 Reset asserted mid-instruction SHALL abandon it; no retire pulse is produced.

Structure
REQ-016 State encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J) and aluOp/aluSrcB/pcSrc codes SHALL live in a shared package, mips_ctrl_pkg.
REQ-017 The block SHALL be a single module with a state register and next-state/output logic; the output decode MAY be one sub-module, mc_ctrl_decode.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, then R-type (000000) with ready=1: states 0,1,6,7,0; regWrite=1 and regDst=1 only in state 7; done pulse at cycle 4.
- lw (100011) with ready low 3 cycles in MEMRD: state 3 held 4 cycles with memRead=1 and iorD=1; then state 4 with memToReg=1 and regWrite=1.
- beq (000100): with i_zero=1, pcEn=1 and pcSrc=01 in state 8; with i_zero=0, pcEn=0; next state 0 in both cases.
- Opcode 111111: o_illegal pulses in state 1; next state 0; regWrite and memWrite never assert.
- sw with i_rst asserted in MEMWR while ready=0: next state 0, memWrite drops, no done pulse.
- FETCH with ready=0 for 2 cycles: irWrite=pcEn=0 while waiting, both 1 on the ready cycle, then DECODE.
